// File: rtl/dlfloat_operand_sequencer_if.sv
// Handshake bundle between the word source, the operand sequencer and the DLFloat16 MAC.
// The sequencer connects through the slave modport; the surrounding logic drives the master side.
interface dlfloat_operand_sequencer_if;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mac_a;
   logic [15:0] mac_b;
   logic        mac_valid;
   logic        mac_ready;
   logic        mac_clear;
   logic        mac_last;
   logic        busy;
   logic        err_nan;

   modport master (
      output in_data, in_valid, mac_ready,
      input  in_ready, mac_a, mac_b, mac_valid, mac_clear, mac_last, busy, err_nan
   );

   modport slave (
      input  in_data, in_valid, mac_ready,
      output in_ready, mac_a, mac_b, mac_valid, mac_clear, mac_last, busy, err_nan
   );
endinterface

// File: rtl/dlfloat_operand_sequencer.sv
// Turns a header-prefixed word stream into tagged DLFloat16 operand pairs for a MAC via a small FIFO.
// Optional: define DLF_SEQ_NAN_DETECT_EN to build the sticky 16'hFFFF operand detector (err_nan).
module dlfloat_operand_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8
) (
   input logic                          clk,
   input logic                          rst_n,
   dlfloat_operand_sequencer_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GET_A = 2'd1;
   localparam logic [1:0] ST_GET_B = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]       state_r;
   logic [LEN_W-1:0] rem_r;
   logic [15:0]      a_hold_r;
   logic             pend_clr_r;
   logic [33:0]      mem_r [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             err_nan_r;

   logic             in_ready_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             mac_valid_s;
   logic [33:0]      head_s;
   logic [LEN_W-1:0] hdr_len_s;
   logic             last_pair_s;

   assign full_s      = (count_r == CW'(FIFO_DEPTH));
   assign mac_valid_s = (count_r != {CW{1'b0}});
   assign head_s      = mem_r[rd_ptr_r];
   assign hdr_len_s   = bus.in_data[LEN_W-1:0];
   assign last_pair_s = (rem_r == LEN_W'(1));

   // Acceptance window per state; GET_B additionally waits for FIFO room.
   always_comb begin
      in_ready_s = 1'b0;
      case (state_r)
         ST_IDLE:  in_ready_s = 1'b1;
         ST_GET_A: in_ready_s = 1'b1;
         ST_GET_B: in_ready_s = !full_s;
         default:  in_ready_s = 1'b0;
      endcase
   end

   // rst_n gates ready so nothing looks acceptable while reset is held.
   assign bus.in_ready = rst_n & in_ready_s;
   assign accept_s     = bus.in_valid & bus.in_ready;
   assign push_s       = accept_s & (state_r == ST_GET_B);
   assign pop_s        = mac_valid_s & bus.mac_ready;

   // Empty FIFO forces the MAC operands and tags to zero.
   assign bus.mac_valid = mac_valid_s;
   assign bus.mac_clear = mac_valid_s & head_s[33];
   assign bus.mac_last  = mac_valid_s & head_s[32];
   assign bus.mac_a     = mac_valid_s ? head_s[31:16] : 16'h0000;
   assign bus.mac_b     = mac_valid_s ? head_s[15:0]  : 16'h0000;
   assign bus.busy      = (state_r != ST_IDLE);
   assign bus.err_nan   = err_nan_r;

   // Job sequencing: header, then alternating A/B operands, then wait for the last pair to leave.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         rem_r      <= {LEN_W{1'b0}};
         a_hold_r   <= 16'h0000;
         pend_clr_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  rem_r <= hdr_len_s;
                  if (hdr_len_s != {LEN_W{1'b0}}) begin
                     state_r    <= ST_GET_A;
                     pend_clr_r <= bus.in_data[15];
                  end
               end
            end
            ST_GET_A: begin
               if (accept_s) begin
                  a_hold_r <= bus.in_data;
                  state_r  <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (push_s) begin
                  rem_r      <= rem_r - LEN_W'(1);
                  pend_clr_r <= 1'b0;
                  state_r    <= last_pair_s ? ST_DRAIN : ST_GET_A;
               end
            end
            ST_DRAIN: begin
               if (pop_s && head_s[32] && (count_r == CW'(1))) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Pair FIFO; entry layout is {clear, last, a, b}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 34'd0;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {pend_clr_r, last_pair_s, a_hold_r, bus.in_data};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef DLF_SEQ_NAN_DETECT_EN
   // Sticky all-ones operand flag, cleared by the next header.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_nan_r <= 1'b0;
      end else if (accept_s && (state_r == ST_IDLE)) begin
         err_nan_r <= 1'b0;
      end else if (accept_s && (bus.in_data == 16'hFFFF)) begin
         err_nan_r <= 1'b1;
      end
   end
`else
   assign err_nan_r = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_operand_sequencer.sv
// Directed bench for dlfloat_operand_sequencer: job framing, back-pressure, reset and err_nan.
module tb_dlfloat_operand_sequencer;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

`ifdef DLF_SEQ_NAN_DETECT_EN
   localparam logic NAN_EN = 1'b1;
`else
   localparam logic NAN_EN = 1'b0;
`endif

   dlfloat_operand_sequencer_if bus ();

   dlfloat_operand_sequencer #(.FIFO_DEPTH(4), .LEN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Presents one word, waits (bounded) for acceptance, then idles the input.
   task automatic send(input logic [15:0] w);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk1("send_timeout", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h0000;
   endtask

   initial begin
      logic [15:0] words [16];
      int idx;
      int pairs;
      int lasts;
      logic rdy;
      logic vld;
      logic pop;

      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h0000;
      bus.mac_ready = 1'b0;

      // Reset state
      #12;
      chk1("rst_in_ready", bus.in_ready, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_mac_valid", bus.mac_valid, 1'b0);
      chk16("rst_mac_a", bus.mac_a, 16'h0000);
      chk16("rst_mac_b", bus.mac_b, 16'h0000);
      chk1("rst_err_nan", bus.err_nan, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("idle_in_ready", bus.in_ready, 1'b1);

      // Two-pair job with clear
      bus.mac_ready = 1'b1;
      send(16'h8002);
      chk1("t1_busy", bus.busy, 1'b1);
      chk1("t1_no_valid", bus.mac_valid, 1'b0);
      send(16'h3E00);
      send(16'h4000);
      chk1("t1_p1_valid", bus.mac_valid, 1'b1);
      chk16("t1_p1_a", bus.mac_a, 16'h3E00);
      chk16("t1_p1_b", bus.mac_b, 16'h4000);
      chk1("t1_p1_clear", bus.mac_clear, 1'b1);
      chk1("t1_p1_last", bus.mac_last, 1'b0);
      send(16'h3E00);
      chk1("t1_gap_valid", bus.mac_valid, 1'b0);
      chk16("t1_gap_a", bus.mac_a, 16'h0000);
      send(16'h3E00);
      chk1("t1_p2_valid", bus.mac_valid, 1'b1);
      chk16("t1_p2_a", bus.mac_a, 16'h3E00);
      chk16("t1_p2_b", bus.mac_b, 16'h3E00);
      chk1("t1_p2_clear", bus.mac_clear, 1'b0);
      chk1("t1_p2_last", bus.mac_last, 1'b1);
      chk1("t1_drain_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      chk1("t1_end_busy", bus.busy, 1'b0);
      chk1("t1_end_valid", bus.mac_valid, 1'b0);
      chk1("t1_end_ready", bus.in_ready, 1'b1);

      // Zero-length header, then a real header
      send(16'h0000);
      chk1("t2_busy", bus.busy, 1'b0);
      chk1("t2_valid", bus.mac_valid, 1'b0);
      send(16'h0001);
      chk1("t2_hdr_busy", bus.busy, 1'b1);
      send(16'h1111);
      send(16'h2222);
      chk16("t2_a", bus.mac_a, 16'h1111);
      chk16("t2_b", bus.mac_b, 16'h2222);
      chk1("t2_clear", bus.mac_clear, 1'b0);
      chk1("t2_last", bus.mac_last, 1'b1);
      @(posedge clk); #1;
      chk1("t2_end_busy", bus.busy, 1'b0);

      // Back-pressure: six pairs into a four-entry FIFO with the MAC stalled
      words[0] = 16'h0006;
      for (int i = 1; i < 16; i++) words[i] = 16'h0100 + 16'(i);
      bus.mac_ready = 1'b0;
      idx = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = words[0];
      for (int c = 0; c < 20; c++) begin
         rdy = bus.in_ready;
         vld = bus.in_valid;
         @(posedge clk); #1;
         if (rdy && vld) idx++;
         if (idx < 13) bus.in_data = words[idx];
         else begin bus.in_valid = 1'b0; bus.in_data = 16'h0000; end
      end
      chk16("t3_stall_idx", 16'(idx), 16'd10);
      chk1("t3_stall_ready", bus.in_ready, 1'b0);
      chk1("t3_stall_valid", bus.mac_valid, 1'b1);
      chk16("t3_hold_a", bus.mac_a, 16'h0101);
      chk16("t3_hold_b", bus.mac_b, 16'h0102);
      bus.mac_ready = 1'b1;
      pairs = 0;
      lasts = 0;
      for (int c = 0; c < 40; c++) begin
         rdy = bus.in_ready;
         vld = bus.in_valid;
         pop = bus.mac_valid & bus.mac_ready;
         if (pop && pairs < 6) begin
            chk16("t3_pair_a", bus.mac_a, words[2 * pairs + 1]);
            chk16("t3_pair_b", bus.mac_b, words[2 * pairs + 2]);
            chk1("t3_pair_last", bus.mac_last, (pairs == 5));
         end
         if (pop) begin
            if (bus.mac_last) lasts++;
            pairs++;
         end
         @(posedge clk); #1;
         if (rdy && vld) idx++;
         if (idx < 13) bus.in_data = words[idx];
         else begin bus.in_valid = 1'b0; bus.in_data = 16'h0000; end
      end
      chk16("t3_pairs", 16'(pairs), 16'd6);
      chk16("t3_lasts", 16'(lasts), 16'd1);
      chk16("t3_words", 16'(idx), 16'd13);
      chk1("t3_end_busy", bus.busy, 1'b0);

      // Reset in the middle of an N=5 job
      bus.mac_ready = 1'b0;
      send(16'h0005);
      for (int i = 0; i < 6; i++) send(16'h0200 + 16'(i));
      chk1("t4_pre_valid", bus.mac_valid, 1'b1);
      chk1("t4_pre_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("t4_rst_valid", bus.mac_valid, 1'b0);
      chk16("t4_rst_a", bus.mac_a, 16'h0000);
      chk16("t4_rst_b", bus.mac_b, 16'h0000);
      chk1("t4_rst_busy", bus.busy, 1'b0);
      chk1("t4_rst_ready", bus.in_ready, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      bus.mac_ready = 1'b1;
      send(16'h0001);
      send(16'hAAAA);
      send(16'hBBBB);
      chk1("t4_post_valid", bus.mac_valid, 1'b1);
      chk16("t4_post_a", bus.mac_a, 16'hAAAA);
      chk16("t4_post_b", bus.mac_b, 16'hBBBB);
      chk1("t4_post_last", bus.mac_last, 1'b1);
      pairs = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.mac_valid) pairs++;
         @(posedge clk); #1;
      end
      chk16("t4_one_pair", 16'(pairs), 16'd1);
      chk1("t4_end_busy", bus.busy, 1'b0);

      // All-ones operand detection
      send(16'h0001);
      send(16'hFFFF);
      chk1("t5_nan_set", bus.err_nan, NAN_EN);
      send(16'h1234);
      chk16("t5_fwd_a", bus.mac_a, 16'hFFFF);
      chk16("t5_fwd_b", bus.mac_b, 16'h1234);
      @(posedge clk); #1;
      chk1("t5_nan_sticky", bus.err_nan, NAN_EN);
      send(16'h0000);
      chk1("t5_nan_clear", bus.err_nan, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dlfloat_operand_sequencer.md
DLFLOAT_OPERAND_SEQUENCER -- requirements
Module: dlfloat_operand_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of operand-pair entries buffered; power of two, 2..16.
REQ-002 Parameter LEN_W, default 8, width of the pair-count field taken from the header word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  16  pin-assembled word: header or DLFloat16 operand.
REQ-006 in_valid  input  1  in_data holds a valid word.
REQ-007 in_ready  output  1  sequencer accepts in_data this cycle.
REQ-008 mac_a  output  16  DLFloat16 multiplicand to the MAC.
REQ-009 mac_b  output  16  DLFloat16 multiplier to the MAC.
REQ-010 mac_valid  output  1  mac_a/mac_b carry a valid pair.
REQ-011 mac_ready  input  1  MAC consumes the pair; tied high when the MAC has no stall.
REQ-012 mac_clear  output  1  accumulator clear, qualified by mac_valid, first pair of a job only.
REQ-013 mac_last  output  1  qualifies the final pair of a job.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err_nan  output  1  sticky flag: a 16'hFFFF operand was seen in the current job.

Function
REQ-016 Transfer on in_valid && in_ready; pop on mac_valid && mac_ready.
REQ-017 FSM states: IDLE, GET_A, GET_B, DRAIN.
REQ-018 IDLE: in_ready=1; accepted word is the header: N=in_data[LEN_W-1:0], CLR=in_data[15]; N latched into a remaining-pair counter.
REQ-019 Header with N=0: state stays IDLE, no pair issued, err_nan cleared.
REQ-020 Header with N>0: next state GET_A, CLR latched into a pending-clear flag.
REQ-021 GET_A: in_ready=1; accepted word is stored in a_hold; next state GET_B.
REQ-022 GET_B: in_ready=!full; accepted word pushed with a_hold as {a,b} into the FIFO together with first/last tags; counter decrements.
REQ-023 After a GET_B push: remaining count 0 -> DRAIN, otherwise -> GET_A.
REQ-024 DRAIN: in_ready=0; DRAIN -> IDLE on the cycle the FIFO becomes empty after popping the last-tagged pair.
REQ-025 Push-to-output latency is exactly one cycle: a pair pushed at edge k is visible on mac_a/mac_b with mac_valid=1 after edge k, when the FIFO was empty.
REQ-026 mac_valid equals FIFO not-empty.
REQ-027 When mac_valid=0, mac_a, mac_b, mac_clear and mac_last are all 0, so the MAC sees 0*0.
REQ-028 mac_clear=1 only with the first pair of a job whose CLR=1; mac_last=1 only with pair N.
REQ-029 Full FIFO: in_ready is low in GET_B; a push and a pop in the same cycle on a non-full FIFO keep the occupancy unchanged.
REQ-030 Pairs leave in arrival order; pointers wrap modulo FIFO_DEPTH.
REQ-031 mac_ready=0 holds mac_a, mac_b, mac_clear and mac_last stable.

Reset
REQ-032 rst_n low asynchronously forces IDLE, empty FIFO, counter 0, a_hold 0, pending-clear 0, err_nan 0.
REQ-033 Under reset, in_ready=0, busy=0 and all mac_* outputs are 0.
REQ-034 Reset mid-job discards all buffered pairs; the next accepted word after release is a header.

Configuration
REQ-035 Macro DLF_SEQ_NAN_DETECT_EN defined: err_nan is set when any accepted operand equals 16'hFFFF and cleared on the next header accept; the pair is still forwarded unchanged.
REQ-036 Macro DLF_SEQ_NAN_DETECT_EN undefined: err_nan is constant 0 and no detection logic is built.

Verification
REQ-037 Header 16'h8002, then 16'h3E00, 16'h4000, 16'h3E00, 16'h3E00 with mac_ready=1 -> two pairs in order; pair 1 has mac_clear=1, pair 2 has mac_last=1; busy drops after the last pop.
REQ-038 Header 16'h0000 -> no mac_valid; busy stays 0; the next word is treated as a header.
REQ-039 mac_ready=0, header 16'h0006 plus 12 operands -> in_ready drops after 4 pairs; on release of mac_ready all 6 pairs emerge in order; exactly one mac_last.
REQ-040 rst_n pulsed low after 3 pairs of an N=5 job -> all outputs 0 immediately; post-release header 16'h0001 with one pair yields exactly one pair.
REQ-041 With DLF_SEQ_NAN_DETECT_EN defined, operand 16'hFFFF -> err_nan=1 until the next header; the pair is forwarded as 16'hFFFF. With the macro undefined, err_nan stays 0.
